// File: rtl/spi_slave.sv
// SPI mode-0 target: oversamples ssb/sck/mosi in the clk domain, shifts MSB-first,
// and exchanges one byte per eight SCK periods with the CPU-side holding buffer.
module spi_slave #(
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       ssb,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] data_in,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] data_out,
  output logic       new_data,
  output logic       busy,
  output logic       tx_underrun
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t     state_q, state_d;
  // [0],[1] are the synchroniser stages, [2] is the edge-detect history.
  logic [2:0] ssb_sync_q, ssb_sync_d;
  logic [2:0] sck_sync_q, sck_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       bit_seen_q, bit_seen_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] data_out_q, data_out_d;
  logic       new_data_q, new_data_d;
  logic       underrun_q, underrun_d;

  logic rise, fall, sel_start, sel_end, slot_start;

  assign rise      =  sck_sync_q[1] & ~sck_sync_q[2];
  assign fall      = ~sck_sync_q[1] &  sck_sync_q[2];
  assign sel_start = ~ssb_sync_q[1] &  ssb_sync_q[2];
  assign sel_end   =  ssb_sync_q[1] & ~ssb_sync_q[2];

  // CPU handshake: a byte transfers on any cycle where tx_load && tx_ready;
  // tx_load while tx_ready is low is dropped, tx_ready reflects an empty buffer.
  assign tx_ready    = ~hold_full_q;
  assign miso        = tx_q[7];
  assign miso_oe     = (state_q == S_ACTIVE);
  assign busy        = ~ssb_sync_q[1];
  assign data_out    = data_out_q;
  assign new_data    = new_data_q;
  assign tx_underrun = underrun_q;

  always_comb begin
    state_d     = state_q;
    ssb_sync_d  = {ssb_sync_q[1:0], ssb};
    sck_sync_d  = {sck_sync_q[1:0], sck};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    bit_cnt_d   = bit_cnt_q;
    bit_seen_d  = bit_seen_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    data_out_d  = data_out_q;
    new_data_d  = 1'b0;
    underrun_d  = 1'b0;
    slot_start  = 1'b0;

    if (tx_load && !hold_full_q) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        bit_cnt_d  = 3'd0;
        bit_seen_d = 1'b0;
        if (sel_start) begin
          state_d    = S_ACTIVE;
          slot_start = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (sel_end) begin
          state_d    = S_IDLE;
          bit_cnt_d  = 3'd0;
          bit_seen_d = 1'b0;
          tx_d       = 8'h00;
        end else if (rise) begin
          rx_d       = {rx_q[6:0], mosi_sync_q[1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          bit_seen_d = 1'b1;
          if (bit_cnt_q == 3'd7) begin
            data_out_d = {rx_q[6:0], mosi_sync_q[1]};
            new_data_d = 1'b1;
          end
        end else if (fall) begin
          // A fall before any rise (selected with sck high) must not open a slot.
          if (bit_cnt_q != 3'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
          end else if (bit_seen_q) begin
            slot_start = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (slot_start) begin
      bit_seen_d = 1'b0;
      if (hold_full_q) begin
        tx_d        = hold_q;
        hold_full_d = 1'b0;
      end else if (tx_load) begin
        tx_d        = data_in;
        hold_full_d = 1'b0;
      end else begin
        tx_d       = DEFAULT_TX;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      ssb_sync_q  <= 3'b111;
      sck_sync_q  <= 3'b000;
      mosi_sync_q <= 2'b00;
      bit_cnt_q   <= 3'd0;
      bit_seen_q  <= 1'b0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      data_out_q  <= 8'h00;
      new_data_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ssb_sync_q  <= ssb_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_seen_q  <= bit_seen_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      data_out_q  <= data_out_d;
      new_data_q  <= new_data_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master drives 2 MHz mode-0 transfers,
// expected bytes go into queues and monitors pop them as the DUT presents results.
`timescale 1ns/1ps
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rstb, ssb, sck, mosi, miso, miso_oe;
  logic [7:0] data_in, data_out;
  logic       tx_load, tx_ready, new_data, busy, tx_underrun;

  int checks = 0;
  int errors = 0;
  int nd_cnt = 0;
  int ur_cnt = 0;
  int nd0, ur0;
  logic nd_prev = 1'b0;
  logic ur_prev = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] rd_byte;
  event       rd_ev;
  longint     last_rise_t = 0;
  longint     p1;

  spi_slave #(.DEFAULT_TX(8'hFF)) dut (
    .clk(clk), .rstb(rstb), .ssb(ssb), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .data_in(data_in), .tx_load(tx_load),
    .tx_ready(tx_ready), .data_out(data_out), .new_data(new_data),
    .busy(busy), .tx_underrun(tx_underrun)
  );

  // Clock/reset: posedges at 10+20k ns, negedges at 20k ns.
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic cpu_load(input logic [7:0] v);
    @(negedge clk);
    data_in = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  // Pin edges land 5 ns off the clk edges so sampling is never ambiguous.
  task automatic select(input bit load_at_start, input logic [7:0] v);
    @(negedge clk);
    #5 ssb = 1'b0;
    if (load_at_start) begin
      @(negedge clk);
      @(negedge clk);
      data_in = v;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      @(negedge clk);
      check("tx_ready_bypass", tx_ready, 1);
      #5;
    end
  endtask

  task automatic deselect();
    repeat (4) @(negedge clk);
    #5 ssb = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input logic [7:0] exp_rx, input int n);
    logic [7:0] r = 8'h00;
    if (n == 8) begin
      exp_q.push_back(tx);
      exp_miso_q.push_back(exp_rx);
    end
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      #250 sck = 1'b1;
      r[7-i] = miso;
      #250 sck = 1'b0;
    end
    if (n == 8) begin
      rd_byte = r;
      -> rd_ev;
    end
  endtask

  always @(posedge sck) last_rise_t = $time;

  // Scoreboard monitor for received bytes, pulse widths and latency.
  always @(negedge clk) begin
    if (rstb === 1'b1) begin
      if (new_data) begin
        nd_cnt++;
        if (nd_prev) begin
          check("new_data_width", 2, 1);
        end else begin
          p1 = ((last_rise_t - 10) / 20 + 1) * 20 + 10;
          check("new_data_latency", $time, p1 + 50);
          if (exp_q.size() == 0) check("data_out_unexpected", data_out, 8'hxx);
          else check("data_out", data_out, exp_q.pop_front());
        end
      end
      if (tx_underrun) begin
        ur_cnt++;
        if (ur_prev) check("underrun_width", 2, 1);
      end
    end
    nd_prev = new_data;
    ur_prev = tx_underrun;
  end

  always @(rd_ev) begin
    if (exp_miso_q.size() == 0) check("miso_unexpected", rd_byte, 8'hxx);
    else check("miso_byte", rd_byte, exp_miso_q.pop_front());
  end

  initial begin
    rstb = 1'b0; ssb = 1'b1; sck = 1'b0; mosi = 1'b0;
    data_in = 8'h00; tx_load = 1'b0;
    repeat (4) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_data_out", data_out, 8'h00);
    check("rst_new_data", new_data, 0);
    check("rst_tx_underrun", tx_underrun, 0);

    // Preloaded A5 out, 3C in.
    cpu_load(8'hA5);
    @(negedge clk);
    check("tx_ready_after_load", tx_ready, 0);
    nd0 = nd_cnt; ur0 = ur_cnt;
    select(1'b0, 8'h00);
    spi_bits(8'h3C, 8'hA5, 8);
    check("busy_selected", busy, 1);
    check("miso_oe_selected", miso_oe, 1);
    deselect();
    check("t2_new_data_count", nd_cnt - nd0, 1);
    check("t2_underrun_count", ur_cnt - ur0, 1);
    check("t2_tx_ready", tx_ready, 1);

    // Three bytes, only the first queued; slot 4 is fed so it does not underrun.
    cpu_load(8'h11);
    nd0 = nd_cnt; ur0 = ur_cnt;
    select(1'b0, 8'h00);
    spi_bits(8'h01, 8'h11, 8);
    spi_bits(8'h02, 8'hFF, 8);
    fork
      spi_bits(8'h03, 8'hFF, 8);
      begin
        #1000;
        cpu_load(8'h77);
      end
    join
    deselect();
    check("t3_new_data_count", nd_cnt - nd0, 3);
    check("t3_underrun_count", ur_cnt - ur0, 2);
    check("t3_tx_ready", tx_ready, 1);

    // Aborted partial byte, then a fresh full byte.
    nd0 = nd_cnt;
    select(1'b0, 8'h00);
    spi_bits(8'hB0, 8'h00, 5);
    deselect();
    check("t4_no_new_data", nd_cnt - nd0, 0);
    check("t4_busy", busy, 0);
    check("t4_miso_oe", miso_oe, 0);
    check("t4_miso", miso, 0);
    select(1'b0, 8'h00);
    spi_bits(8'hC3, 8'hFF, 8);
    deselect();
    check("t4_new_data_count", nd_cnt - nd0, 1);

    // Bypass load in the sel_start cycle.
    ur0 = ur_cnt;
    select(1'b1, 8'h5A);
    check("t5_no_underrun", ur_cnt - ur0, 0);
    spi_bits(8'h6E, 8'h5A, 8);
    deselect();

    // Reset mid-byte, then reselect; the second load must be ignored.
    select(1'b0, 8'h00);
    spi_bits(8'hF0, 8'h00, 4);
    @(negedge clk);
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("t6_data_out_after_reset", data_out, 8'h00);
    check("t6_tx_ready_after_reset", tx_ready, 1);
    check("t6_new_data_after_reset", new_data, 0);
    deselect();
    cpu_load(8'h3E);
    cpu_load(8'h99);
    @(negedge clk);
    check("t6_tx_ready_full", tx_ready, 0);
    nd0 = nd_cnt;
    select(1'b0, 8'h00);
    spi_bits(8'h96, 8'h3E, 8);
    deselect();
    check("t6_new_data_count", nd_cnt - nd0, 1);
    check("t6_data_out", data_out, 8'h96);
    check("t6_tx_ready_empty", tx_ready, 1);

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_miso_q_drained", exp_miso_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
